// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, Gray-coded conversion, then row-by-row readout.
// All array controls are registered; they are decoded from the next state so they line up with the state register.
module pixel_frame_ctrl #(
   parameter int ERASE_CYCLES  = 5,
   parameter int EXPOSE_CYCLES = 255,
   parameter int CNT_W         = 8,
   parameter int N_ROWS        = 2,
   parameter int N_COLS        = 2,
   parameter int ROW_W         = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             continuous,
   output logic             erase,
   output logic             expose,
   output logic             convert,
   output logic [CNT_W-1:0] cnt_gray,
   output logic             read,
   output logic [ROW_W-1:0] row_pointer,
   output logic             busy,
   output logic             frame_done
);

   localparam int CONV_CYCLES = 2 ** CNT_W;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // The shared phase counter must reach the longest phase, including the full conversion ramp.
   localparam int PH_MAX = max2(max2(ERASE_CYCLES, EXPOSE_CYCLES), max2(CONV_CYCLES, N_COLS));
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PH_W-1:0]  ERASE_LAST  = PH_W'(ERASE_CYCLES - 1);
   localparam logic [PH_W-1:0]  EXPOSE_LAST = PH_W'(EXPOSE_CYCLES - 1);
   localparam logic [PH_W-1:0]  CONV_LAST   = PH_W'(CONV_CYCLES - 1);
   localparam logic [PH_W-1:0]  COL_LAST    = PH_W'(N_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(N_ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ERASE     = 3'd1,
      S_EXPOSE    = 3'd2,
      S_CONVERT   = 3'd3,
      S_ROW_SETUP = 3'd4,
      S_ROW_READ  = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [PH_W-1:0] phase_cnt;
   logic [PH_W-1:0] phase_nxt;

   logic             erase_d;
   logic             expose_d;
   logic             convert_d;
   logic [CNT_W-1:0] cnt_gray_d;
   logic [CNT_W-1:0] conv_b;
   logic             read_d;
   logic [ROW_W-1:0] row_d;
   logic             busy_d;
   logic             frame_done_d;

   // State, phase counter and all outputs share one register stage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         phase_cnt   <= '0;
         erase       <= 1'b0;
         expose      <= 1'b0;
         convert     <= 1'b0;
         cnt_gray    <= '0;
         read        <= 1'b0;
         row_pointer <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state       <= next_state;
         phase_cnt   <= phase_nxt;
         erase       <= erase_d;
         expose      <= expose_d;
         convert     <= convert_d;
         cnt_gray    <= cnt_gray_d;
         read        <= read_d;
         row_pointer <= row_d;
         busy        <= busy_d;
         frame_done  <= frame_done_d;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (start) next_state = S_ERASE;
         S_ERASE:     if (phase_cnt == ERASE_LAST) next_state = S_EXPOSE;
         S_EXPOSE:    if (phase_cnt == EXPOSE_LAST) next_state = S_CONVERT;
         S_CONVERT:   if (phase_cnt == CONV_LAST) next_state = S_ROW_SETUP;
         S_ROW_SETUP: next_state = S_ROW_READ;
         S_ROW_READ: begin
            if (phase_cnt == COL_LAST) begin
               next_state = (row_pointer == ROW_LAST) ? S_DONE : S_ROW_SETUP;
            end
         end
         S_DONE:      next_state = continuous ? S_ERASE : S_IDLE;
         default:     next_state = S_IDLE;
      endcase
      // Every state lasts at least one cycle, so a state change always marks a fresh entry.
      phase_nxt = (next_state != state) ? '0 : phase_cnt + PH_W'(1);
   end

   always_comb begin
      erase_d      = 1'b0;
      expose_d     = 1'b0;
      convert_d    = 1'b0;
      cnt_gray_d   = '0;
      read_d       = 1'b0;
      row_d        = '0;
      busy_d       = (next_state != S_IDLE);
      frame_done_d = 1'b0;
      conv_b       = phase_nxt[CNT_W-1:0];
      case (next_state)
         S_ERASE:   erase_d  = 1'b1;
         S_EXPOSE:  expose_d = 1'b1;
         S_CONVERT: begin
            convert_d  = 1'b1;
            cnt_gray_d = conv_b ^ (conv_b >> 1);
         end
         // First row after conversion starts at 0; each later setup advances one row.
         S_ROW_SETUP: row_d = (state == S_ROW_READ) ? row_pointer + ROW_W'(1) : '0;
         S_ROW_READ: begin
            read_d = 1'b1;
            row_d  = row_pointer;
         end
         S_DONE:    frame_done_d = 1'b1;
         default:   ;
      endcase
   end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Directed bench for pixel_frame_ctrl: timeline table per frame cycle, plus continuous,
// mid-frame reset, start-while-busy and randomized exclusivity sequences.
module tb_pixel_frame_ctrl;

   localparam int ERASE_CYCLES  = 3;
   localparam int EXPOSE_CYCLES = 5;
   localparam int CNT_W         = 4;
   localparam int N_ROWS        = 2;
   localparam int N_COLS        = 2;
   localparam int ROW_W         = 1;
   localparam int FRAME_LEN     = 31;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             continuous;
   logic             erase;
   logic             expose;
   logic             convert;
   logic [CNT_W-1:0] cnt_gray;
   logic             read;
   logic [ROW_W-1:0] row_pointer;
   logic             busy;
   logic             frame_done;

   int checks = 0;
   int errors = 0;

   // Output segments of one frame, cycles counted after the edge that samples start.
   // ctl = {erase, expose, convert, read, row_pointer, busy, frame_done}
   typedef struct {
      int         lo;
      int         hi;
      logic [6:0] ctl;
   } seg_t;

   seg_t       segs[8];
   logic [3:0] gray_tab[16];

   pixel_frame_ctrl #(
      .ERASE_CYCLES  (ERASE_CYCLES),
      .EXPOSE_CYCLES (EXPOSE_CYCLES),
      .CNT_W         (CNT_W),
      .N_ROWS        (N_ROWS),
      .N_COLS        (N_COLS),
      .ROW_W         (ROW_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .continuous  (continuous),
      .erase       (erase),
      .expose      (expose),
      .convert     (convert),
      .cnt_gray    (cnt_gray),
      .read        (read),
      .row_pointer (row_pointer),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] act_out();
      return {erase, expose, convert, read, row_pointer, busy, frame_done, cnt_gray};
   endfunction

   function automatic logic [10:0] exp_out(input int c);
      logic [6:0] ctl;
      logic [3:0] g;
      ctl = '0;
      g   = '0;
      for (int i = 0; i < 8; i++) begin
         if (c >= segs[i].lo && c <= segs[i].hi) ctl = segs[i].ctl;
      end
      if (c >= 9 && c <= 24) g = gray_tab[c-9];
      return {ctl, g};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Checks frame cycles 1..n; returns positioned in cycle n+1.
   task automatic check_frame(input string tag, input int n);
      for (int c = 1; c <= n; c++) begin
         chk($sformatf("%s cyc%0d", tag, c), 32'(act_out()), 32'(exp_out(c)));
         step();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int viol;

      segs[0] = '{1, 3, 7'b1000010};
      segs[1] = '{4, 8, 7'b0100010};
      segs[2] = '{9, 24, 7'b0010010};
      segs[3] = '{25, 25, 7'b0000010};
      segs[4] = '{26, 27, 7'b0001010};
      segs[5] = '{28, 28, 7'b0000110};
      segs[6] = '{29, 30, 7'b0001110};
      segs[7] = '{31, 31, 7'b0000011};
      gray_tab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                   4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

      // Reset state, with start asserted alongside reset: reset must win.
      reset      = 1'b0;
      start      = 1'b1;
      continuous = 1'b0;
      step();
      step();
      chk("reset_with_start", 32'(act_out()), 32'd0);
      start = 1'b0;
      reset = 1'b1;
      step();
      chk("idle_after_reset", 32'(act_out()), 32'd0);

      // Single frame with full timeline and Gray sequence.
      pulse_start();
      check_frame("single", FRAME_LEN);
      chk("single idle cyc32", 32'(act_out()), 32'(exp_out(32)));
      step();
      chk("single idle cyc33", 32'(act_out()), 32'd0);

      // Continuous: second frame back-to-back, continuous dropped during it.
      continuous = 1'b1;
      pulse_start();
      check_frame("cont_f1", FRAME_LEN);
      continuous = 1'b0;
      check_frame("cont_f2", FRAME_LEN);
      chk("cont idle cyc63", 32'(act_out()), 32'd0);
      step();

      // Mid-frame reset during conversion, then a clean frame.
      pulse_start();
      check_frame("midrst", 11);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("midrst outputs cleared", 32'(act_out()), 32'd0);
      step();
      chk("midrst stays idle", 32'(act_out()), 32'd0);
      pulse_start();
      check_frame("after_rst", FRAME_LEN);
      chk("after_rst idle", 32'(act_out()), 32'd0);
      step();

      // Start held high: no restart until IDLE is reached in cycle 32.
      start = 1'b1;
      step();
      check_frame("hold_f1", FRAME_LEN);
      chk("hold idle cyc32", 32'(act_out()), 32'd0);
      step();
      start = 1'b0;
      check_frame("hold_f2", FRAME_LEN);
      chk("hold idle end", 32'(act_out()), 32'd0);

      // Random control stimulus: controls mutually exclusive, row pointer in range.
      viol = 0;
      for (int i = 0; i < 10000; i++) begin
         start      = 1'($urandom_range(0, 1));
         continuous = ($urandom_range(0, 3) == 0);
         reset      = ($urandom_range(0, 49) != 0);
         step();
         if (!$onehot0({erase, expose, convert, read})) viol++;
         if (int'(row_pointer) >= N_ROWS) viol++;
         if (!convert && cnt_gray != '0) viol++;
      end
      chk("random exclusivity violations", 32'(viol), 32'd0);

      start      = 1'b0;
      continuous = 1'b0;
      do_reset();
      step();
      chk("final idle", 32'(act_out()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
